// File: rtl/sprite_ram_arbiter.sv
// Sprite frame RAM port sharer: round-robin tagged reads, priority loader writes.
// Read data returns two cycles after grant, steered by the captured requester tag.
module sprite_ram_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 5,
    parameter int DEPTH  = 400
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    input  logic                      wr_req,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ack,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_write_address,
    output logic [DATA_W-1:0]         ram_data_In,
    output logic [ADDR_W-1:0]         ram_read_address,
    input  logic [DATA_W-1:0]         ram_data_Out,
    output logic                      range_err
);

    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [TAG_W-1:0]  ptr;
    logic [TAG_W-1:0]  sel;
    logic              rd_xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_oor;
    logic              wr_xfer;
    logic              wr_oor;

    logic              s1_valid, s2_valid;
    logic [TAG_W-1:0]  s1_tag, s2_tag;
    logic              s1_oor, s2_oor;

    // Rotating priority search starting at ptr; writes and reset suppress all grants.
    always_comb begin
        logic [TAG_W:0]   sum;
        logic [TAG_W-1:0] idx;
        gnt     = '0;
        sel     = '0;
        rd_xfer = 1'b0;
        sum     = '0;
        idx     = '0;
        if (Reset && !wr_req) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                sum = {1'b0, ptr} + (TAG_W+1)'(k);
                if (sum >= (TAG_W+1)'(N_REQ))
                    sum = sum - (TAG_W+1)'(N_REQ);
                idx = sum[TAG_W-1:0];
                if (!rd_xfer && req[idx]) begin
                    rd_xfer  = 1'b1;
                    sel      = idx;
                    gnt[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt[k])
                sel_addr = addr[k*ADDR_W +: ADDR_W];
        end
    end

    assign sel_oor = sel_addr >= ADDR_W'(DEPTH);
    assign wr_oor  = wr_addr  >= ADDR_W'(DEPTH);
    assign wr_ack  = Reset & wr_req;
    assign wr_xfer = wr_ack;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ptr               <= '0;
            ram_we            <= 1'b0;
            ram_write_address <= '0;
            ram_data_In       <= '0;
            ram_read_address  <= '0;
            s1_valid          <= 1'b0;
            s1_tag            <= '0;
            s1_oor            <= 1'b0;
            s2_valid          <= 1'b0;
            s2_tag            <= '0;
            s2_oor            <= 1'b0;
            range_err         <= 1'b0;
        end else begin
            ram_we    <= wr_xfer && !wr_oor;
            range_err <= (wr_xfer && wr_oor) || (rd_xfer && sel_oor);
            if (wr_xfer && !wr_oor) begin
                ram_write_address <= wr_addr;
                ram_data_In       <= wr_data;
            end
            // Out-of-range reads still flow down the pipe so the requester gets its reply.
            if (rd_xfer) begin
                ptr <= (sel == TAG_W'(N_REQ-1)) ? '0 : sel + 1'b1;
                if (!sel_oor)
                    ram_read_address <= sel_addr;
            end
            s1_valid <= rd_xfer;
            s1_tag   <= sel;
            s1_oor   <= sel_oor;
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_oor   <= s1_oor;
        end
    end

    always_comb begin
        rd_valid = '0;
        if (s2_valid)
            rd_valid[s2_tag] = 1'b1;
    end

    assign rd_data = (s2_valid && !s2_oor) ? ram_data_Out : '0;

endmodule

// File: doc/sprite_ram_arbiter.md
# sprite_ram_arbiter

Shares the single read port and single write port of one sprite frame RAM (20x20 sprite, 400 entries, 5-bit data port) between up to N_REQ pixel-fetch requesters and one sprite loader. Reads are granted round-robin, one per cycle; loader writes take absolute priority. It sits between the per-object draw logic (duck, shot duck, crosshair) and the frameRAM instance, hiding the RAM's one-cycle registered read latency behind a tagged return.

## Interface
Parameters:
- N_REQ, 4, number of read requesters (1..8)
- ADDR_W, 19, RAM address width
- DATA_W, 5, RAM data width
- DEPTH, 400, valid addresses 0..DEPTH-1

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- req  in  N_REQ  read request, one bit per requester, level
- addr  in  N_REQ*ADDR_W  read address; requester i at [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot read grant, combinational
- rd_valid  out  N_REQ  one-hot read-data valid
- rd_data  out  DATA_W  read data for requester flagged by rd_valid
- wr_req  in  1  loader write request
- wr_addr  in  ADDR_W  loader write address
- wr_data  in  DATA_W  loader write data
- wr_ack  out  1  write accepted, combinational
- ram_we  out  1  to frameRAM we
- ram_write_address  out  ADDR_W  to frameRAM write_address
- ram_data_In  out  DATA_W  to frameRAM data_In
- ram_read_address  out  ADDR_W  to frameRAM read_address
- ram_data_Out  in  DATA_W  from frameRAM data_Out
- range_err  out  1  one-cycle pulse on out-of-range access

## Operation
- Transfer: read transfer for requester i occurs at a rising edge where req[i] & gnt[i]; write transfer where wr_req & wr_ack. Requesters hold req/addr stable until granted; holding req high after a grant requests another access.
- Write priority: wr_req high (out of reset) -> wr_ack=1, gnt=0 that cycle regardless of req.
- Round-robin: registered pointer ptr (0..N_REQ-1). With no wr_req, gnt goes to first i with req[i] searching ptr, ptr+1, ... modulo N_REQ. On read transfer to i, ptr <= (i+1) mod N_REQ. ptr unchanged when no read transfer.
- Read path: on transfer, ram_read_address <= addr[i], tag <= i, pipe stage 1 valid. Next edge stage 2 valid/tag follow; rd_valid[tag]=stage-2 valid, rd_data = ram_data_Out.
- Write path: on transfer, ram_we <= 1, ram_write_address <= wr_addr, ram_data_In <= wr_data for one cycle; otherwise ram_we <= 0, address/data hold.
- Range check: addr >= DEPTH on read -> transfer accepted, ram_read_address held, rd_valid still returned with rd_data forced to 0; range_err pulses the cycle after transfer. wr_addr >= DEPTH -> wr_ack still given, ram_we stays 0, range_err pulses the cycle after.
- Reset (Reset=0 at an edge): ptr=0, ram_we=0, ram_write_address=0, ram_data_In=0, ram_read_address=0, pipe valids=0, range_err=0. While Reset=0, gnt=0 and wr_ack=0. In-flight reads are discarded: no rd_valid after reset.

## Timing
- Read accepted at edge of cycle t: ram_read_address valid cycle t+1; RAM registers at end of t+1; rd_valid/rd_data valid cycle t+2 for exactly one cycle. Latency 2, throughput 1 read/cycle.
- Write accepted cycle t: ram_we high cycle t+1; memory updated at end of t+1.
- Read-after-write coherence: a write accepted in cycle t blocks reads in t; the earliest read accepted in t+1 samples the RAM at end of t+2 and returns the new data.
- Back-to-back reads from different requesters return in acceptance order, one per cycle, with correct tags.
- A single requester holding req with all others idle is granted every cycle.

## Test plan
- Reset: Reset=0 two cycles with req=4'b1111, wr_req=1 -> gnt=0, wr_ack=0, ram_we=0, rd_valid=0, range_err=0; after release gnt=4'b0001 first.
- Round-robin: req=4'b1111 held 8 cycles, preloaded mem[k]=k -> gnt sequence 0,1,2,3,0,1,2,3; rd_valid follows two cycles later with rd_data equal to each requester's addr.
- Write priority/coherence: wr_req at cycle t (addr 37, data 5'h1F) with req[2]=1 addr 37 -> gnt=0 in t, gnt[2] in t+1, rd_valid[2] at t+3 with rd_data=5'h1F.
- Out of range: req[1] addr 400 -> rd_valid[1] two cycles later with rd_data=0, range_err pulse one cycle after grant, ram_read_address unchanged; wr_addr 512 -> wr_ack=1, ram_we stays 0, range_err pulse.
- Reset mid-read: read accepted cycle t, Reset=0 at t+1 -> no rd_valid at t+2; ptr=0 afterward.
- Single requester streaming: req[3] held 10 cycles, addr incrementing on each gnt -> 10 consecutive grants, 10 consecutive rd_valid[3] pulses, data in address order.
